// File: rtl/menu_dispatcher.sv
// Top-level menu dispatcher: idle screen, one-hot child selection, error screen.
// Optional inactivity timeout in ACTIVE is enabled by defining MENU_DISPATCH_TIMEOUT_EN.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | menu screen shown, waiting for con (select) or rls (leave)
//  S_ACTIVE | child sel enabled, its show word routed to the display
//  S_ERROR  | invalid selection, ERR_SHOW held for ERR_CYCLES cycles
module menu_dispatcher #(
    parameter int                NUM_MODES      = 3,
    parameter int                SW_W           = 8,
    parameter int                SHOW_W         = 30,
    parameter logic [SHOW_W-1:0] IDLE_SHOW      = {5'd23, 5'd10, 5'd20, 5'd10, 5'd30, 5'd14},
    parameter logic [SHOW_W-1:0] ERR_SHOW       = {5'd14, 5'd24, 5'd24, 5'd21, 5'd24, 5'd31},
    parameter int                ERR_CYCLES     = 100_000_000,
    parameter int                TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [2:0]                    press,
    input  logic [SW_W-1:0]               switch,
    input  logic [NUM_MODES-1:0]          child_done_i,
    input  logic [NUM_MODES*SHOW_W-1:0]   child_show_i,
    output logic [NUM_MODES-1:0]          child_en_o,
    output logic [SHOW_W-1:0]             show_o,
    output logic [NUM_MODES-1:0]          mode_led_o,
    output logic                          father_rst_o,
    output logic                          err_o
);

    localparam int SEL_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_CYCLES - 1);
    localparam logic [SW_W-1:0]  MODE_MASK = SW_W'((64'd1 << NUM_MODES) - 64'd1);

    localparam logic [2:0] P_RLS = 3'b001;
    localparam logic [2:0] P_CON = 3'b010;
    localparam logic [2:0] P_RIS = 3'b100;

    if (NUM_MODES < 1 || NUM_MODES > 8 || SW_W < NUM_MODES ||
        ERR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("menu_dispatcher: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [ERR_W-1:0]   err_cnt, err_cnt_nxt;
    logic               switch_valid;
    logic               tmo_hit;

    logic [NUM_MODES-1:0] child_en_nxt;
    logic [SHOW_W-1:0]    show_nxt;
    logic                 father_nxt;
    logic                 err_nxt;

    function automatic logic [SEL_W-1:0] hot_index(input logic [SW_W-1:0] v);
        hot_index = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (v[i]) hot_index = SEL_W'(i);
        end
    endfunction

    // Exactly one switch high, and it must name an existing child.
    assign switch_valid = $onehot(switch) && ((switch & ~MODE_MASK) == '0);

`ifdef MENU_DISPATCH_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       P_NONE   = 3'b111;

    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;

    always_comb begin
        tmo_cnt_nxt = '0;
        tmo_hit     = 1'b0;
        if (state == S_ACTIVE && press == P_NONE) begin
            if (tmo_cnt == TMO_LAST) tmo_hit = 1'b1;
            else                     tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) tmo_cnt <= '0;
        else               tmo_cnt <= tmo_cnt_nxt;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            state        <= S_IDLE;
            sel          <= '0;
            err_cnt      <= '0;
            child_en_o   <= '0;
            show_o       <= '1;
            father_rst_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            err_cnt      <= err_cnt_nxt;
            child_en_o   <= child_en_nxt;
            show_o       <= show_nxt;
            father_rst_o <= father_nxt;
            err_o        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        err_cnt_nxt = '0;
        case (state)
            S_IDLE: begin
                if (press == P_CON) begin
                    if (switch_valid) begin
                        state_nxt = S_ACTIVE;
                        sel_nxt   = hot_index(switch);
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_ACTIVE: begin
                if (press == P_RIS || child_done_i[sel] || tmo_hit) state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (err_cnt == ERR_LAST) state_nxt = S_IDLE;
                else                     err_cnt_nxt = err_cnt + ERR_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they change with it.
    always_comb begin
        child_en_nxt = '0;
        show_nxt     = IDLE_SHOW;
        father_nxt   = (state == S_IDLE) && (press == P_RLS);
        err_nxt      = 1'b0;
        case (state_nxt)
            S_ACTIVE: begin
                child_en_nxt = NUM_MODES'(1) << sel_nxt;
                show_nxt     = child_show_i[sel_nxt*SHOW_W +: SHOW_W];
            end
            S_ERROR: begin
                show_nxt = ERR_SHOW;
                err_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mode_led_o = child_en_o;

endmodule

// File: tb/tb_menu_dispatcher.sv
// Self-checking bench for menu_dispatcher: directed scenarios plus a randomized
// run compared against a screen-level reference model.
module tb_menu_dispatcher;

    localparam int N    = 3;
    localparam int SW   = 8;
    localparam int SH   = 30;
    localparam int ERRC = 4;
    localparam int TMO  = 8;

    localparam logic [SH-1:0] IDLE_S = {5'd23, 5'd10, 5'd20, 5'd10, 5'd30, 5'd14};
    localparam logic [SH-1:0] ERR_S  = {5'd14, 5'd24, 5'd24, 5'd21, 5'd24, 5'd31};
    localparam logic [SH-1:0] BLANK  = '1;

    localparam logic [2:0] NXT  = 3'b000;
    localparam logic [2:0] RLS  = 3'b001;
    localparam logic [2:0] CON  = 3'b010;
    localparam logic [2:0] DEL  = 3'b011;
    localparam logic [2:0] RIS  = 3'b100;
    localparam logic [2:0] NONE = 3'b111;

    logic            clk = 1'b0;
    logic            rst_n, en;
    logic [2:0]      press;
    logic [SW-1:0]   switch;
    logic [N-1:0]    child_done_i;
    logic [N*SH-1:0] child_show_i;
    logic [N-1:0]    child_en_o, mode_led_o;
    logic [SH-1:0]   show_o;
    logic            father_rst_o, err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: where the menu is (0 idle, 1 active, 2 error) and how long.
    int            m_where = 0;
    int            m_sel   = 0;
    int            m_errn  = 0;
    int            m_quiet = 0;
    logic [N-1:0]  e_child;
    logic [SH-1:0] e_show;
    logic          e_father, e_err;

    always #5 clk = ~clk;

    menu_dispatcher #(
        .NUM_MODES(N), .SW_W(SW), .SHOW_W(SH),
        .ERR_CYCLES(ERRC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .press(press), .switch(switch),
        .child_done_i(child_done_i), .child_show_i(child_show_i),
        .child_en_o(child_en_o), .show_o(show_o), .mode_led_o(mode_led_o),
        .father_rst_o(father_rst_o), .err_o(err_o)
    );

    task automatic model_update();
        int k;
        if (!rst_n || !en) begin
            m_where = 0; m_sel = 0; m_errn = 0; m_quiet = 0;
            e_child = '0; e_show = BLANK; e_father = 1'b0; e_err = 1'b0;
            return;
        end
        e_father = (m_where == 0) && (press == RLS);
        case (m_where)
            0: if (press == CON) begin
                k = -1;
                for (int i = 0; i < SW; i++) if (switch == (8'd1 << i)) k = i;
                if (k >= 0 && k < N) begin m_where = 1; m_sel = k; m_quiet = 0; end
                else begin m_where = 2; m_errn = 0; end
            end
            1: begin
                if (press == RIS || child_done_i[m_sel]) m_where = 0;
`ifdef MENU_DISPATCH_TIMEOUT_EN
                else if (press == NONE) begin
                    m_quiet++;
                    if (m_quiet == TMO) m_where = 0;
                end else m_quiet = 0;
`endif
            end
            default: begin
                m_errn++;
                if (m_errn == ERRC) m_where = 0;
            end
        endcase
        e_child = (m_where == 1) ? N'(1 << m_sel) : '0;
        e_err   = (m_where == 2);
        e_show  = (m_where == 0) ? IDLE_S :
                  (m_where == 2) ? ERR_S  : child_show_i[m_sel*SH +: SH];
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; press = NONE; switch = '0;
        child_done_i = '0; child_show_i = '0;
        cyc(); cyc();
        n_tests++;
        if (show_o !== BLANK || child_en_o !== '0 || mode_led_o !== '0 ||
            err_o !== 1'b0 || father_rst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: show=%h en=%b led=%b err=%b fr=%b want show=%h rest 0",
                     show_o, child_en_o, mode_led_o, err_o, father_rst_o, BLANK);
        end
        rst_n = 1'b1;
        cyc();
        n_tests++;
        if (show_o !== IDLE_S) begin
            n_fail++; $display("FAIL reset_idle_show: got %h want %h", show_o, IDLE_S);
        end
    endtask

    task automatic test_select();
        child_show_i = {30'h2AAAA, 30'h12345, 30'h0BEEF};
        switch = 8'b0000_0010; press = CON;
        cyc();
        n_tests++;
        if (child_en_o !== 3'b010 || mode_led_o !== 3'b010) begin
            n_fail++; $display("FAIL select_en: en=%b led=%b want 010", child_en_o, mode_led_o);
        end
        switch = 8'b0000_0001;   // con still held, switch moved: neither may matter
        cyc();
        press = NONE;
        n_tests++;
        if (show_o !== 30'h12345 || child_en_o !== 3'b010) begin
            n_fail++; $display("FAIL select_show: show=%h en=%b want 12345 010", show_o, child_en_o);
        end
        child_show_i[SH +: SH] = 30'h3C0F0;
        cyc();
        n_tests++;
        if (show_o !== 30'h3C0F0) begin
            n_fail++; $display("FAIL select_follow: got %h want 3c0f0", show_o);
        end
    endtask

    task automatic test_child_done();
        child_done_i = 3'b001;
        cyc();
        n_tests++;
        if (child_en_o !== 3'b010) begin
            n_fail++; $display("FAIL done_other: en=%b want 010", child_en_o);
        end
        child_done_i = 3'b010;
        cyc();
        child_done_i = '0;
        n_tests++;
        if (child_en_o !== 3'b000 || show_o !== IDLE_S) begin
            n_fail++; $display("FAIL done_sel: en=%b show=%h want 000 %h", child_en_o, show_o, IDLE_S);
        end
    endtask

    task automatic test_error();
        logic [SW-1:0] pats [4] = '{8'b0000_0110, 8'b0000_0000, 8'b0000_1000, 8'b1000_0000};
        foreach (pats[p]) begin
            switch = pats[p]; press = CON;
            cyc();
            n_tests++;
            if (err_o !== 1'b1 || show_o !== ERR_S || child_en_o !== '0) begin
                n_fail++; $display("FAIL err_enter sw=%b: err=%b show=%h want 1 %h", pats[p], err_o, show_o, ERR_S);
            end
            switch = 8'b0000_0001;
            for (int i = 0; i < ERRC - 1; i++) begin
                press = (i < 2) ? CON : NONE;
                cyc();
                n_tests++;
                if (err_o !== 1'b1 || show_o !== ERR_S) begin
                    n_fail++; $display("FAIL err_hold cyc=%0d: err=%b show=%h want 1 %h", i + 2, err_o, show_o, ERR_S);
                end
            end
            press = NONE;
            cyc();
            n_tests++;
            if (err_o !== 1'b0 || show_o !== IDLE_S || child_en_o !== '0) begin
                n_fail++; $display("FAIL err_exit: err=%b show=%h en=%b want 0 %h 000", err_o, show_o, child_en_o, IDLE_S);
            end
        end
    endtask

    task automatic test_rls();
        press = RLS;
        cyc();
        n_tests++;
        if (father_rst_o !== 1'b1 || show_o !== IDLE_S) begin
            n_fail++; $display("FAIL rls_pulse: fr=%b show=%h want 1 %h", father_rst_o, show_o, IDLE_S);
        end
        press = NONE;
        cyc();
        n_tests++;
        if (father_rst_o !== 1'b0) begin
            n_fail++; $display("FAIL rls_single: fr=%b want 0", father_rst_o);
        end
        switch = 8'b0000_0100; press = CON; cyc();
        press = RLS; cyc();
        n_tests++;
        if (father_rst_o !== 1'b0 || child_en_o !== 3'b100) begin
            n_fail++; $display("FAIL rls_active: fr=%b en=%b want 0 100", father_rst_o, child_en_o);
        end
        press = RIS; cyc();
        press = NONE;
    endtask

    task automatic test_en_drop();
        switch = 8'b0000_0001; press = CON; cyc();
        press = NONE; cyc();
        en = 1'b0; press = RIS; child_done_i = 3'b001;
        cyc();
        n_tests++;
        if (child_en_o !== '0 || show_o !== BLANK || err_o !== 1'b0) begin
            n_fail++; $display("FAIL en_drop: en=%b show=%h want 000 %h", child_en_o, show_o, BLANK);
        end
        en = 1'b1; press = NONE; child_done_i = '0;
        cyc();
        n_tests++;
        if (show_o !== IDLE_S || child_en_o !== '0) begin
            n_fail++; $display("FAIL en_restore: show=%h en=%b want %h 000", show_o, child_en_o, IDLE_S);
        end
    endtask

    task automatic test_both_exit();
        switch = 8'b0000_0100; press = CON; cyc();
        press = NONE; cyc();
        press = RIS; child_done_i = 3'b100;
        cyc();
        n_tests++;
        if (child_en_o !== '0 || show_o !== IDLE_S) begin
            n_fail++; $display("FAIL both_exit: en=%b show=%h want 000 %h", child_en_o, show_o, IDLE_S);
        end
        cyc();
        n_tests++;
        if (child_en_o !== '0 || show_o !== IDLE_S || err_o !== 1'b0) begin
            n_fail++; $display("FAIL both_held: en=%b show=%h want 000 %h", child_en_o, show_o, IDLE_S);
        end
        press = NONE; child_done_i = '0;
    endtask

`ifdef MENU_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        switch = 8'b0000_0010; press = CON; cyc();
        press = NONE;
        for (int i = 1; i <= TMO; i++) begin
            cyc();
            n_tests++;
            if (child_en_o !== ((i < TMO) ? 3'b010 : 3'b000)) begin
                n_fail++; $display("FAIL timeout_quiet cyc=%0d: en=%b", i, child_en_o);
            end
        end
        press = CON; cyc();
        for (int i = 1; i <= TMO; i++) begin
            press = (i == 5) ? NXT : NONE;
            cyc();
            n_tests++;
            if (child_en_o !== 3'b010) begin
                n_fail++; $display("FAIL timeout_restart cyc=%0d: en=%b want 010", i, child_en_o);
            end
        end
        press = RIS; cyc();
        press = NONE;
    endtask
`else
    task automatic test_persist();
        switch = 8'b0000_0001; press = CON; cyc();
        press = NONE;
        repeat (40) cyc();
        n_tests++;
        if (child_en_o !== 3'b001) begin
            n_fail++; $display("FAIL persist: en=%b want 001", child_en_o);
        end
        press = RIS; cyc();
        press = NONE;
    endtask
`endif

    task automatic test_random();
        logic [2:0] codes [6] = '{NXT, RLS, CON, DEL, RIS, NONE};
        for (int c = 0; c < 600; c++) begin
            en     = ($urandom_range(0, 29) != 0);
            press  = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 5)] : NONE;
            switch = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'(1 << $urandom_range(0, 7));
            child_done_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            child_show_i = {$urandom, $urandom, $urandom};
            cyc();
            n_tests++;
            if ({child_en_o, mode_led_o, show_o, father_rst_o, err_o} !==
                {e_child, e_child, e_show, e_father, e_err}) begin
                n_fail++;
                $display("FAIL random c=%0d: en=%b led=%b show=%h fr=%b err=%b want en=%b show=%h fr=%b err=%b",
                         c, child_en_o, mode_led_o, show_o, father_rst_o, err_o,
                         e_child, e_show, e_father, e_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_child_done();
        test_error();
        test_rls();
        test_en_drop();
        test_both_exit();
`ifdef MENU_DISPATCH_TIMEOUT_EN
        test_timeout();
`else
        test_persist();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
